// File: rtl/lns_pkg.sv
// rtl/lns_pkg.sv - shared constants, word type and saturation helper for the LNS decoder
package lns_pkg;

  // Log word geometry: Q6.5 signed log2 magnitude
  localparam int LOG_W     = 11;
  localparam int FRAC_BITS = 5;
  localparam int EXP_W     = LOG_W - FRAC_BITS;
  localparam int LOG_ZERO  = -1024;

  // Mantissa is Q1.12, so 2^(f/32) spans 4096..8016 in 13 bits
  localparam int MANT_FRAC = 12;
  localparam int MANT_W    = MANT_FRAC + 1;

  typedef struct packed {
    logic                    sign;
    logic signed [LOG_W-1:0] log;
  } lns_word_t;

  // Largest positive magnitude representable in a signed out_w-bit result
  function automatic logic [63:0] sat_limit(input int unsigned out_w);
    return (64'd1 << (out_w - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/lns_exp2_frac.sv
// rtl/lns_exp2_frac.sv - 32-entry table of round(4096 * 2^(f/32))
module lns_exp2_frac
  import lns_pkg::*;
(
  input  logic [FRAC_BITS-1:0] f,
  output logic [MANT_W-1:0]    mant
);

  // Fractional exponent to Q1.12 mantissa lookup
  always_comb begin
    mant = 13'd4096;
    case (f)
      5'd0:  mant = 13'd4096;
      5'd1:  mant = 13'd4186;
      5'd2:  mant = 13'd4277;
      5'd3:  mant = 13'd4371;
      5'd4:  mant = 13'd4467;
      5'd5:  mant = 13'd4565;
      5'd6:  mant = 13'd4664;
      5'd7:  mant = 13'd4767;
      5'd8:  mant = 13'd4871;
      5'd9:  mant = 13'd4978;
      5'd10: mant = 13'd5087;
      5'd11: mant = 13'd5198;
      5'd12: mant = 13'd5312;
      5'd13: mant = 13'd5428;
      5'd14: mant = 13'd5547;
      5'd15: mant = 13'd5668;
      5'd16: mant = 13'd5793;
      5'd17: mant = 13'd5919;
      5'd18: mant = 13'd6049;
      5'd19: mant = 13'd6182;
      5'd20: mant = 13'd6317;
      5'd21: mant = 13'd6455;
      5'd22: mant = 13'd6597;
      5'd23: mant = 13'd6741;
      5'd24: mant = 13'd6889;
      5'd25: mant = 13'd7039;
      5'd26: mant = 13'd7194;
      5'd27: mant = 13'd7351;
      5'd28: mant = 13'd7512;
      5'd29: mant = 13'd7677;
      5'd30: mant = 13'd7845;
      5'd31: mant = 13'd8016;
      default: mant = 13'd4096;
    endcase
  end

endmodule

// File: rtl/lns_to_fix.sv
// rtl/lns_to_fix.sv - 3-stage signed-log LNS to Q(OUT_W-12).12 fixed-point decoder
module lns_to_fix
  import lns_pkg::*;
#(
  parameter int OUT_W = 24,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [LOG_W-1:0] in_log,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_sat,
  output logic             out_uflow
);

  localparam logic [63:0] SAT_LIM = sat_limit(OUT_W);

  // Whole pipeline moves as one; a stalled output freezes every stage
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  lns_word_t in_word;
  assign in_word = {in_sign, in_log};

  // Stage 1 inputs: floor exponent is just the upper bits of the log word
  logic signed [EXP_W-1:0] e_in;
  logic [FRAC_BITS-1:0]    f_in;
  logic [MANT_W-1:0]       mant_in;
  logic                    zero_in;

  assign e_in    = in_word.log[LOG_W-1:FRAC_BITS];
  assign f_in    = in_word.log[FRAC_BITS-1:0];
  assign zero_in = (in_word.log == LOG_W'(LOG_ZERO));

  lns_exp2_frac u_exp2 (
    .f    (f_in),
    .mant (mant_in)
  );

  logic                    v1, sign1, zero1;
  logic signed [EXP_W-1:0] e1;
  logic [MANT_W-1:0]       mant1;
  logic [TAG_W-1:0]        tag1;

  // S1: register the split exponent, looked-up mantissa and sideband
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      sign1 <= 1'b0;
      zero1 <= 1'b0;
      e1    <= '0;
      mant1 <= '0;
      tag1  <= '0;
    end else if (adv) begin
      v1    <= in_valid;
      sign1 <= in_word.sign;
      zero1 <= zero_in;
      e1    <= e_in;
      mant1 <= mant_in;
      tag1  <= in_tag;
    end
  end

  // Stage 2 datapath: 64 bits holds 8016 << 31 without wrapping
  logic [EXP_W-1:0] neg_e;
  logic [63:0]      wide;
  logic             sat_c, uflow_c;

  assign neg_e = EXP_W'(-e1);

  // Scale the mantissa by 2^e, truncating bits shifted out on the right
  always_comb begin
    wide = '0;
    if (!e1[EXP_W-1]) wide = 64'(mant1) << e1[EXP_W-2:0];
    else              wide = 64'(mant1) >> neg_e;
  end

  assign sat_c   = !e1[EXP_W-1] && (wide > SAT_LIM);
  assign uflow_c = !zero1 && (wide == 64'd0);

  logic             v2, sign2, zero2, sat2, uflow2;
  logic [OUT_W-2:0] mag2;
  logic [TAG_W-1:0] tag2;

  // S2: register the unsigned magnitude and its range flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2     <= 1'b0;
      sign2  <= 1'b0;
      zero2  <= 1'b0;
      sat2   <= 1'b0;
      uflow2 <= 1'b0;
      mag2   <= '0;
      tag2   <= '0;
    end else if (adv) begin
      v2     <= v1;
      sign2  <= sign1;
      zero2  <= zero1;
      sat2   <= sat_c;
      uflow2 <= uflow_c;
      mag2   <= wide[OUT_W-2:0];
      tag2   <= tag1;
    end
  end

  // Stage 3: zero wins, then clamp, then apply sign symmetrically
  logic [OUT_W-1:0] mag_sel, res;

  always_comb begin
    mag_sel = '0;
    if (zero2)     mag_sel = '0;
    else if (sat2) mag_sel = {1'b0, SAT_LIM[OUT_W-2:0]};
    else           mag_sel = {1'b0, mag2};
    res = sign2 ? (-mag_sel) : mag_sel;
  end

  // S3: output register, only reloaded when a real sample is advancing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_sat   <= 1'b0;
      out_uflow <= 1'b0;
    end else if (adv) begin
      out_valid <= v2;
      if (v2) begin
        out_data  <= res;
        out_tag   <= tag2;
        out_sat   <= sat2 && !zero2;
        out_uflow <= uflow2;
      end
    end
  end

endmodule

// File: doc/lns_to_fix.md
Name: lns_to_fix

Overview:
- Pipelined LNS-to-linear decoder: converts a signed-log LNS word into a signed two's-complement fixed-point value.
- Counterpart of the sb/Gauss-log LUT path, which maps linear ratios into the log domain; this block maps log-domain results back out.
- Sits at the output of the LNS fmadd datapath and feeds fixed-point consumers and scoreboards.
- Valid/ready streaming interface with a passthrough sideband tag.

Parameters:
- OUT_W, 24, output width in bits; Q(OUT_W-12).12 format; legal range 16..32.
- TAG_W, 4, width of the sideband tag carried alongside each sample.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block accepts the input word this cycle.
- in_sign  input  1  sign of the linear value; 1 = negative.
- in_log  input  11  signed log2 magnitude in Q6.5 (5 fractional bits); -1024 encodes zero.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  output valid.
- out_ready  input  1  downstream accepts the output.
- out_data  output  OUT_W  signed fixed-point result, Q(OUT_W-12).12.
- out_tag  output  TAG_W  tag delivered with out_data.
- out_sat  output  1  result was saturated.
- out_uflow  output  1  nonzero input flushed to 0.

Behaviour:
- Reset: asynchronous, active-high; all stage valids, out_valid, out_data, out_tag, out_sat and out_uflow clear to 0 immediately on assertion. Reset mid-stream discards all in-flight data.
- Pipeline: 3 register stages; latency 3 cycles from the accepting in_valid & in_ready edge to out_valid with no stalls.
  - S1: split in_log into e = in_log >>> 5 (arithmetic, floor, range -32..31) and f = in_log[4:0]. Look up mant = round(4096 * 2^(f/32)), a 13-bit Q1.12 value in 4096..8016. Register sign, zero flag (in_log == -1024) and tag.
  - S2: if e >= 0, mag = mant << e; otherwise mag = mant >> (-e), truncated. Compute sat = (e >= 0) && (mant << e) > 2^(OUT_W-1)-1. Compute uflow = !zero && mag == 0. Widths are wide enough that no intermediate wraps.
  - S3: if zero, output 0. If sat, magnitude = 2^(OUT_W-1)-1. Negate when sign = 1, so negative saturation is symmetric at -(2^(OUT_W-1)-1). Register out_sat and out_uflow.
- Handshake:
  - Global enable: adv = !out_valid || out_ready. All stages shift on adv; in_ready = adv.
  - Bubbles move through the pipeline but are not compressed ahead of a stalled output.
  - When out_valid && !out_ready: out_data, out_tag and the flags hold stable, and in_ready = 0.
  - in_valid asserted while in_ready = 0: no transfer; the word is not captured.
- Zero code: -1024 always yields out_data = 0 with sat = uflow = 0, regardless of in_sign (no negative zero).
- in_log = -1023 is a legal nonzero value (e = -32, f = 1); it underflows to 0 with uflow = 1.
- Ordering: strictly in order; the tag pairs with its own sample.

Decomposition:
- Package lns_pkg holds:
  - constants LOG_W = 11, FRAC_BITS = 5, LOG_ZERO = -1024, MANT_FRAC = 12;
  - typedef lns_word_t (sign + log);
  - the saturation-limit function of OUT_W.
- One sub-module, lns_exp2_frac: combinational 32-entry table, 5-bit f in, 13-bit mant out. Required entries: f = 0 -> 4096, f = 8 -> 4871, f = 16 -> 5793, f = 31 -> 8016.

Test Plan:
- Basic conversion, OUT_W = 24, out_ready = 1: (sign 0, log 0) -> 4096; (0, 32) -> 8192; (0, -32) -> 2048; (0, 16) -> 5793; (1, 0) -> -4096. Each appears exactly 3 cycles after acceptance, with tags preserved.
- Zero and underflow: (1, -1024) -> 0 with sat = 0, uflow = 0. (0, -416), i.e. e = -13 -> 0 with uflow = 1. (0, -384) -> 1.
- Saturation: (0, 352), e = 11 -> 8388607 with sat = 1. (1, 352) -> -8388607. (0, 351) -> 8016 << 10 = 8208384 with sat = 0.
- Backpressure: stream 6 words with tags 0..5; drop out_ready for 4 cycles after the first output. out_data must hold, in_ready = 0 during the stall, all 6 outputs arrive in order with no loss or duplication, and in_valid asserted during the stall is not captured.
- Reset mid-stream: assert rst with 3 words in flight. out_valid drops to 0 asynchronously, and after release the next accepted word emerges alone 3 cycles later.
- Sweep: all 2048 in_log values × both signs, compared against a reference model (floor exponent, truncated shift, symmetric saturation).
